eth_irq_gateway: RTL

- Consumer-side interrupt gateway for the Ethernet core. It takes the level-sensitive per-source pending lines (e.g. rx_interrupt_pending, tx_interrupt_pending) and arbitrates them by priority against a threshold.
- It presents a single interrupt line plus a claim/complete handshake to the host hart.
- It sits between the Ethernet interrupt sources and the CPU's external-interrupt input, as a small PLIC-style target.

---
 rtl/eth_irq_gateway.sv | 131 +++++++++++++
 1 files changed

// File: rtl/eth_irq_gateway.sv
// eth_irq_gateway
//   PLIC-style interrupt target for the Ethernet core. Each level-sensitive
//   source runs a small gateway FSM (IDLE/PENDING/CLAIMED). PENDING sources
//   whose priority exceeds the threshold are arbitrated combinationally:
//   the highest priority wins, and ties go to the lowest ID. irq_o is the
//   registered "any eligible" flag.
//
// Ports
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   src_pending_i      level pending per source (bit k = source ID k+1)
//   cfg_v_i/id/data    config write: id 0 = threshold, 1..N = source priority
//   claim_v_i          host claim strobe; claims the source shown on claim_id_o
//   claim_id_o         current winning source ID, 0 = none
//   complete_v_i/id    host complete strobe for a CLAIMED source
//   irq_o              interrupt request to host
//   dbg_state_o        gateway states, 2 bits per source (source 1 in [1:0])
//
// Handshake: cfg_v_i, claim_v_i and complete_v_i are single-cycle strobes
// with no ready. Each strobe is acted on at the rising edge where it is high
// and is always accepted; a strobe that names nothing valid is dropped.
module eth_irq_gateway #(
  parameter int num_src_p    = 2,
  parameter int prio_width_p = 3,
  parameter int id_width_p   = $clog2(num_src_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [num_src_p-1:0]      src_pending_i,
  input  logic                      cfg_v_i,
  input  logic [id_width_p-1:0]     cfg_id_i,
  input  logic [prio_width_p-1:0]   cfg_data_i,
  input  logic                      claim_v_i,
  output logic [id_width_p-1:0]     claim_id_o,
  input  logic                      complete_v_i,
  input  logic [id_width_p-1:0]     complete_id_i,
  output logic                      irq_o,
  output logic [2*num_src_p-1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLAIMED = 2'd2
  } gw_state_t;

  gw_state_t                r_state [num_src_p];
  gw_state_t                w_next  [num_src_p];
  logic [prio_width_p-1:0]  r_prio  [num_src_p];
  logic [prio_width_p-1:0]  r_thresh;
  logic                     r_irq;

  logic [id_width_p-1:0]    w_best_id;
  logic [prio_width_p-1:0]  w_best_prio;
  logic                     w_any_elig;

  // Arbitration. The strict '>' keeps the earlier (lower) ID on ties.
  // Priority 0 can never beat a threshold that is at least 0.
  always_comb begin
    w_best_id   = '0;
    w_best_prio = '0;
    w_any_elig  = 1'b0;
    for (int k = 0; k < num_src_p; k++) begin
      if (r_state[k] == ST_PENDING && r_prio[k] > r_thresh) begin
        if (!w_any_elig || r_prio[k] > w_best_prio) begin
          w_best_id   = id_width_p'(k + 1);
          w_best_prio = r_prio[k];
        end
        w_any_elig = 1'b1;
      end
    end
  end

  assign claim_id_o = w_best_id;
  assign irq_o      = r_irq;

  // Gateway next state. A claim beats a same-cycle level drop. A complete
  // only matches a CLAIMED source, so a same-ID claim+complete cannot collide.
  always_comb begin
    for (int k = 0; k < num_src_p; k++) begin
      w_next[k] = r_state[k];
      case (r_state[k])
        ST_IDLE: begin
          if (src_pending_i[k]) w_next[k] = ST_PENDING;
        end
        ST_PENDING: begin
          if (claim_v_i && claim_id_o == id_width_p'(k + 1))
            w_next[k] = ST_CLAIMED;
          else if (!src_pending_i[k])
            w_next[k] = ST_IDLE;
        end
        ST_CLAIMED: begin
          if (complete_v_i && complete_id_i == id_width_p'(k + 1))
            w_next[k] = ST_IDLE;
        end
        default: w_next[k] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < num_src_p; k++) r_state[k] <= ST_IDLE;
    end else begin
      for (int k = 0; k < num_src_p; k++) r_state[k] <= w_next[k];
    end
  end

  // Config registers. Out-of-range IDs match nothing and are dropped.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_thresh <= '0;
      for (int k = 0; k < num_src_p; k++) r_prio[k] <= '0;
    end else if (cfg_v_i) begin
      if (cfg_id_i == '0) r_thresh <= cfg_data_i;
      for (int k = 0; k < num_src_p; k++) begin
        if (cfg_id_i == id_width_p'(k + 1)) r_prio[k] <= cfg_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_irq <= 1'b0;
    else            r_irq <= w_any_elig;
  end

  always_comb begin
    dbg_state_o = '0;
    for (int k = 0; k < num_src_p; k++) dbg_state_o[2*k +: 2] = r_state[k];
  end

endmodule
